bus_bridge: RTL and testbench
=============================

BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 Parameter SW_SYNC, default 2: number of synchronizer flops on the SW input (legal range 2..3).
REQ-002 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Resetn  input  1  reset, asynchronous and active-low.
REQ-004 Req  input  1  processor access request; held high until Ack is seen.
REQ-005 W  input  1  1 = write, 0 = read; qualified by Req.
REQ-006 ADDR  input  16  processor word address; bits [15:12] select the region.
REQ-007 DOUT  input  16  processor write data.
REQ-008 DIN  output  16  registered read data to the processor; valid while Ack is high.
REQ-009 Ack  output  1  one-cycle completion pulse.
REQ-010 mem_addr  output  12  RAM word address.
REQ-011 mem_data  output  16  RAM write data.
REQ-012 mem_wren  output  1  RAM write enable.
REQ-013 mem_q  input  16  RAM read data; valid in the cycle after an address edge (synchronous RAM).
REQ-014 SW  input  16  asynchronous switch inputs.
REQ-015 led_out  output  16  registered LED value.

Function
REQ-016 Address map: region 0x0 = RAM; 0x1 = LED (read/write); 0x2 = SW (read-only; writes ignored); 0x3..0xF = unmapped (reads return 0x0000, writes ignored, Ack still given).
REQ-017 The FSM SHALL have states IDLE, RD1, RD2 and DONE.
REQ-018 IDLE with Req=1 SHALL capture ADDR, DOUT and W into internal registers at the edge, then go to RD1 for a RAM read and to DONE otherwise.
REQ-019 mem_addr and mem_data SHALL be driven from the captured address [11:0] and the captured data in every state.
REQ-020 RD1 SHALL go to RD2 unconditionally; RD2 SHALL load DIN from mem_q at its exit edge and go to DONE.
REQ-021 For non-RAM reads, DIN SHALL be loaded at the IDLE exit edge: LED region = led_out; SW region = synchronized SW; unmapped = 0x0000.
REQ-022 An LED write SHALL update led_out with the captured data at the IDLE exit edge; an SW or unmapped write SHALL change no state except the FSM.
REQ-023 mem_wren SHALL be 1 only in DONE for a captured RAM write, so the RAM commits at the DONE exit edge.
REQ-024 Ack SHALL be 1 exactly in DONE; DONE SHALL always return to IDLE.
REQ-025 Latency, with the request sampled at edge k and Ack high during the cycle after the stated edge: RAM read Ack after edge k+2; all other accesses Ack after edge k.
REQ-026 DIN SHALL hold its last loaded value until the next read load; writes do not alter DIN.
REQ-027 Req still high in the IDLE cycle after DONE SHALL be treated as a new request (back-to-back accesses, one idle cycle minimum).
REQ-028 ADDR, DOUT, W and Req changes outside IDLE SHALL be ignored.
REQ-029 SW SHALL pass through a SW_SYNC-deep flop chain before use; a read returns the value at the last stage.

Reset
REQ-030 Resetn=0 SHALL immediately force: state IDLE, Ack=0, mem_wren=0, DIN=0x0000, led_out=0x0000, captured regs=0, synchronizer flops=0.
REQ-031 Reset during RD1/RD2/DONE SHALL abandon the access: no RAM write committed, no Ack issued, and after release only a fresh Req in IDLE starts an access.

Verification
REQ-032 Write 0x1005 <- 0xBEEF, then read 0x1000 -> Ack 1 cycle after each sample; led_out=0xBEEF after the first; DIN=0xBEEF on the second Ack.
REQ-033 RAM write 0x0123 <- 0x5A5A, then read 0x0123 -> mem_wren high exactly one cycle at mem_addr=0x123; read Ack 3 cycles after the sample with DIN=0x5A5A.
REQ-034 SW=0x00F0 steady for 3 cycles, read 0x2000 -> DIN=0x00F0; write 0x2000 <- 0xFFFF -> no change to led_out or RAM.
REQ-035 Read 0x7000 and write 0xF000 <- 0x1234 -> read gives DIN=0x0000; both give one Ack; mem_wren never high; led_out unchanged.
REQ-036 Assert Resetn=0 in DONE of a RAM write -> mem_wren drops immediately, RAM unchanged, led_out=0x0000, Ack=0, FSM back in IDLE.

Source files
------------

// File: rtl/bus_bridge.sv
// rtl/bus_bridge.sv - processor-to-RAM/LED/switch bus bridge
//
// Purpose: decodes single processor accesses into a synchronous RAM
// (region 0x0), an LED register (0x1), a synchronized switch input (0x2)
// and an unmapped space (0x3..0xF), returning a one-cycle Ack per access.
//
// Ports:
//   Clock     system clock, rising edge
//   Resetn    asynchronous active-low reset
//   Req       access request, held until Ack
//   W         1 = write, 0 = read
//   ADDR      word address, [15:12] selects region
//   DOUT      processor write data
//   DIN       registered read data, valid while Ack is high
//   Ack       one-cycle completion pulse
//   mem_addr  RAM word address (captured address [11:0])
//   mem_data  RAM write data (captured data)
//   mem_wren  RAM write enable, high only in DONE of a RAM write
//   mem_q     RAM read data, one cycle after the address edge
//   SW        asynchronous switch inputs
//   led_out   registered LED value
module bus_bridge #(
  parameter int SW_SYNC = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Req,
  input  logic        W,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  output logic [15:0] DIN,
  output logic        Ack,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  input  logic [15:0] mem_q,
  input  logic [15:0] SW,
  output logic [15:0] led_out
);

  localparam logic [3:0] REGION_RAM = 4'h0;
  localparam logic [3:0] REGION_LED = 4'h1;
  localparam logic [3:0] REGION_SW  = 4'h2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic        w_q;
  logic [15:0] sw_ff [SW_SYNC];

  // Switch synchronizer chain; only the last stage is ever observed.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < SW_SYNC; i++) begin
        sw_ff[i] <= 16'h0000;
      end
    end else begin
      sw_ff[0] <= SW;
      for (int i = 1; i < SW_SYNC; i++) begin
        sw_ff[i] <= sw_ff[i-1];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      w_q     <= 1'b0;
      DIN     <= 16'h0000;
      Ack     <= 1'b0;
      led_out <= 16'h0000;
    end else begin
      Ack <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            addr_q <= ADDR;
            data_q <= DOUT;
            w_q    <= W;
            if (ADDR[15:12] == REGION_RAM && !W) begin
              state <= RD1;
            end else begin
              // Every non-RAM-read access completes straight away.
              state <= DONE;
              Ack   <= 1'b1;
              if (!W) begin
                case (ADDR[15:12])
                  REGION_LED: DIN <= led_out;
                  REGION_SW:  DIN <= sw_ff[SW_SYNC-1];
                  default:    DIN <= 16'h0000;
                endcase
              end else if (ADDR[15:12] == REGION_LED) begin
                led_out <= DOUT;
              end
            end
          end
        end
        RD1: begin
          // RAM samples the captured address at this cycle's exit edge.
          state <= RD2;
        end
        RD2: begin
          DIN   <= mem_q;
          state <= DONE;
          Ack   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr = addr_q[11:0];
  assign mem_data = data_q;
  // Decoded purely from registers; the async reset drops it immediately
  // because state returns to IDLE.
  assign mem_wren = (state == DONE) && w_q && (addr_q[15:12] == REGION_RAM);

endmodule

// File: tb/tb_bus_bridge.sv
// tb/tb_bus_bridge.sv - self-checking bench for bus_bridge with RAM model and reference model
module tb_bus_bridge;

  logic        Clock;
  logic        Resetn;
  logic        Req;
  logic        W;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic [15:0] DIN;
  logic        Ack;
  logic [11:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [15:0] mem_q;
  logic [15:0] SW;
  logic [15:0] led_out;

  int passed = 0;
  int total  = 0;

  // Synchronous RAM attached to the bridge.
  logic [15:0] ram [4096];

  // Reference state, derived from the access rules alone.
  logic [15:0] ref_ram [4096];
  logic [15:0] ref_led;
  logic [15:0] ref_din;
  logic [15:0] ref_sw;
  int          wren_cycles;
  int          exp_wren_cycles;

  bus_bridge #(.SW_SYNC(2)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Req      (Req),
    .W        (W),
    .ADDR     (ADDR),
    .DOUT     (DOUT),
    .DIN      (DIN),
    .Ack      (Ack),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wren (mem_wren),
    .mem_q    (mem_q),
    .SW       (SW),
    .led_out  (led_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  always @(negedge Clock) begin
    if (mem_wren) wren_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One access. b2b: called while the previous access is still in DONE with
  // Req left high, so the request is sampled one edge later. keep: leave Req
  // high after Ack for a following b2b access.
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit b2b, input bit keep);
    int          cyc;
    int          wr;
    int          exp_lat;
    logic [3:0]  rg;
    rg = a[15:12];
    if (!b2b) @(negedge Clock);
    Req  = 1'b1;
    W    = w;
    ADDR = a;
    DOUT = d;
    exp_lat = (rg == 4'h0 && !w) ? 3 : 1;
    if (b2b) exp_lat++;
    if (!w) begin
      case (rg)
        4'h0:    ref_din = ref_ram[a[11:0]];
        4'h1:    ref_din = ref_led;
        4'h2:    ref_din = ref_sw;
        default: ref_din = 16'h0000;
      endcase
    end else if (rg == 4'h0) begin
      ref_ram[a[11:0]] = d;
      exp_wren_cycles++;
    end else if (rg == 4'h1) begin
      ref_led = d;
    end
    cyc = 0;
    wr  = 0;
    while (cyc < 10) begin
      @(posedge Clock);
      #1;
      cyc++;
      if (mem_wren) begin
        wr++;
        chk("wren_addr", {20'h0, mem_addr}, {20'h0, a[11:0]});
        chk("wren_data", {16'h0, mem_data}, {16'h0, d});
      end
      if (Ack) break;
      // Request inputs are don't-care once the access has been taken.
      if (cyc > (b2b ? 1 : 0)) begin
        ADDR = 16'($urandom);
        DOUT = 16'($urandom);
        W    = 1'($urandom);
      end
    end
    Req = keep;
    chk("ack_latency", cyc, exp_lat);
    chk("wren_count", wr, (rg == 4'h0 && w) ? 1 : 0);
    chk("din", {16'h0, DIN}, {16'h0, ref_din});
    chk("led_out", {16'h0, led_out}, {16'h0, ref_led});
    if (!keep) begin
      @(posedge Clock);
      #1;
      chk("ack_pulse", {31'h0, Ack}, 32'h0);
      chk("wren_after", {31'h0, mem_wren}, 32'h0);
    end
  endtask

  task automatic set_sw(input logic [15:0] v);
    @(negedge Clock);
    SW     = v;
    ref_sw = v;
    repeat (3) @(posedge Clock);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    logic [3:0]  rg;
    bit          w;
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 16'(i * 3 + 1);
      ref_ram[i] = 16'(i * 3 + 1);
    end
    ref_led = 16'h0000;
    ref_din = 16'h0000;
    ref_sw  = 16'h0000;
    wren_cycles     = 0;
    exp_wren_cycles = 0;
    Resetn = 1'b0;
    Req    = 1'b0;
    W      = 1'b0;
    ADDR   = 16'h0000;
    DOUT   = 16'h0000;
    SW     = 16'h0000;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_ack", {31'h0, Ack}, 32'h0);
    chk("rst_wren", {31'h0, mem_wren}, 32'h0);
    chk("rst_din", {16'h0, DIN}, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;

    // LED write then read
    access(1'b1, 16'h1005, 16'hBEEF, 1'b0, 1'b0);
    chk("led_beef", {16'h0, led_out}, 32'h0000BEEF);
    access(1'b0, 16'h1000, 16'h0000, 1'b0, 1'b0);
    chk("led_rd_beef", {16'h0, DIN}, 32'h0000BEEF);

    // RAM write then read
    access(1'b1, 16'h0123, 16'h5A5A, 1'b0, 1'b0);
    access(1'b0, 16'h0123, 16'h0000, 1'b0, 1'b0);
    chk("ram_rd_5a5a", {16'h0, DIN}, 32'h00005A5A);

    // Switch read, switch write ignored
    set_sw(16'h00F0);
    access(1'b0, 16'h2000, 16'h0000, 1'b0, 1'b0);
    chk("sw_rd", {16'h0, DIN}, 32'h000000F0);
    access(1'b1, 16'h2000, 16'hFFFF, 1'b0, 1'b0);

    // Unmapped read and write
    access(1'b0, 16'h7000, 16'h0000, 1'b0, 1'b0);
    chk("unmapped_rd", {16'h0, DIN}, 32'h0);
    access(1'b1, 16'hF000, 16'h1234, 1'b0, 1'b0);

    // Back-to-back chain with Req held high through DONE
    access(1'b1, 16'h0042, 16'h1111, 1'b0, 1'b1);
    access(1'b0, 16'h0042, 16'h0000, 1'b1, 1'b1);
    access(1'b1, 16'h1000, 16'h2222, 1'b1, 1'b1);
    access(1'b0, 16'h1003, 16'h0000, 1'b1, 1'b0);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      rg = 4'($urandom_range(0, 4));
      if (rg == 4'h4) rg = 4'($urandom_range(3, 15));
      a = {rg, 8'h00, 4'($urandom_range(0, 15))};
      d = 16'($urandom);
      w = 1'($urandom);
      if (rg == 4'h2 && !w) set_sw(16'($urandom));
      access(w, a, d, 1'b0, 1'b0);
    end
    chk("wren_total", wren_cycles, exp_wren_cycles);

    // Reset during DONE of a RAM write abandons it
    @(negedge Clock);
    Req  = 1'b1;
    W    = 1'b1;
    ADDR = 16'h0456;
    DOUT = 16'hDEAD;
    @(posedge Clock);
    #1;
    chk("rst_done_wren_pre", {31'h0, mem_wren}, 32'h1);
    Req    = 1'b0;
    Resetn = 1'b0;
    #1;
    chk("rst_done_wren", {31'h0, mem_wren}, 32'h0);
    chk("rst_done_ack", {31'h0, Ack}, 32'h0);
    chk("rst_done_led", {16'h0, led_out}, 32'h0);
    chk("rst_done_din", {16'h0, DIN}, 32'h0);
    ref_led = 16'h0000;
    ref_din = 16'h0000;
    ref_sw  = 16'h0000;
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_idle_ack", {31'h0, Ack}, 32'h0);
    access(1'b0, 16'h0456, 16'h0000, 1'b0, 1'b0);
    chk("rst_ram_kept", {16'h0, DIN}, {16'h0, 16'(16'h0456 * 3 + 1)});
    chk("wren_total_end", wren_cycles, exp_wren_cycles);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
